pulse_peak_detector: RTL

Downstream stage of the trapezoidal shaping filter. It samples the filter output every clock and finds each pulse above a programmable threshold. For each pulse it captures the peak amplitude, the timestamp of the peak and the pulse width. Each result is queued as one event in a small FIFO and read out by the acquisition/readout logic over a valid/ready handshake.

---
 rtl/pulse_peak_detector.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pulse_peak_detector.sv
// Peak finder behind the trapezoidal shaper. It captures the amplitude, timestamp and
// width of each above-threshold pulse and queues the result in a small FWFT event FIFO.
module pulse_peak_detector #(
  parameter int SIZE_FILTER_DATA = 15,
  parameter int THRESHOLD        = 100,
  parameter int HOLDOFF          = 4,
  parameter int TS_WIDTH         = 32,
  parameter int WIDTH_BITS       = 8,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [SIZE_FILTER_DATA:0] filter_data,
  input  logic                          event_ready,
  output logic                          event_valid,
  output logic signed [SIZE_FILTER_DATA:0] event_amp,
  output logic [TS_WIDTH-1:0]           event_time,
  output logic [WIDTH_BITS-1:0]         event_width,
  output logic [15:0]                   drop_count,
  output logic                          busy
);
  localparam int DW = SIZE_FILTER_DATA + 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic signed [DW-1:0] THR       = DW'(THRESHOLD);
  localparam logic [7:0]           HOLD_INIT = 8'(HOLDOFF);
  localparam logic [CW-1:0]        FULL_CNT  = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PEAK = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  typedef struct packed {
    logic [DW-1:0]         amp;
    logic [TS_WIDTH-1:0]   ts;
    logic [WIDTH_BITS-1:0] width;
  } evt_t;

  logic [1:0]              state;
  logic [TS_WIDTH-1:0]     ts;
  logic signed [DW-1:0]    max_amp;
  logic [TS_WIDTH-1:0]     max_ts;
  logic [WIDTH_BITS-1:0]   width;
  logic [7:0]              hcnt;
  logic                    above;
  logic                    pulse_end;

  assign above     = filter_data >= THR;
  assign pulse_end = (state == S_PEAK) && !above;
  assign busy      = state != S_IDLE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      ts      <= '0;
      max_amp <= '0;
      max_ts  <= '0;
      width   <= '0;
      hcnt    <= '0;
    end else begin
      ts <= ts + TS_WIDTH'(1);
      case (state)
        S_IDLE: if (above) begin
          state   <= S_PEAK;
          max_amp <= filter_data;
          max_ts  <= ts;
          width   <= WIDTH_BITS'(1);
        end
        S_PEAK: if (above) begin
          if (width != '1) width <= width + WIDTH_BITS'(1);
          // strict compare keeps the earliest sample of a flat top
          if (filter_data > max_amp) begin
            max_amp <= filter_data;
            max_ts  <= ts;
          end
        end else begin
          hcnt  <= HOLD_INIT;
          state <= (HOLDOFF == 0) ? S_WAIT : S_HOLD;
        end
        S_HOLD: begin
          hcnt <= hcnt - 8'd1;
          if (hcnt == 8'd1) state <= S_WAIT;
        end
        S_WAIT: if (!above) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // One-deep staging register between the tracker and the FIFO.
  evt_t pend;
  logic pend_vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_vld <= 1'b0;
      pend     <= '0;
    end else begin
      pend_vld <= pulse_end;
      if (pulse_end) begin
        pend.amp   <= max_amp;
        pend.ts    <= max_ts;
        pend.width <= width;
      end
    end
  end

  evt_t          mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, pop, push, drop;
  evt_t          head;

  assign event_valid = count != '0;
  assign full        = count == FULL_CNT;
  assign pop         = event_valid & event_ready;
  // a pop on the same edge frees the slot, so a full FIFO still accepts
  assign push        = pend_vld & (~full | pop);
  assign drop        = pend_vld & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pend;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end

  assign head        = event_valid ? mem[rd_ptr] : '0;
  assign event_amp   = $signed(head.amp);
  assign event_time  = head.ts;
  assign event_width = head.width;

endmodule
